sram_arbiter: RTL and testbench

//   Shares one single-port 16x8 sram between two requesters (req0, req1).

---
 rtl/sram_arb_pkg.sv | 11 +
 rtl/rr_arb2.sv | 41 ++++
 rtl/sram_arbiter.sv | 95 +++++++++
 tb/tb_sram_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants and types for the two-requester sram arbiter.
package sram_arb_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int NREQ       = 2;

  // Identifies one of the two requesters.
  typedef logic req_id_t;

endpackage : sram_arb_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins; on a tie the
// requester named by i_prio wins.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic [NREQ-1:0] i_valid,
  input  req_id_t         i_prio,
  output logic [NREQ-1:0] o_grant,
  output req_id_t         o_gid
);

  // Select the winner from the valid pattern and the current priority.
  always_comb begin
    o_grant = 2'b00;
    o_gid   = 1'b0;
    case (i_valid)
      2'b01: begin
        o_grant = 2'b01;
        o_gid   = 1'b0;
      end
      2'b10: begin
        o_grant = 2'b10;
        o_gid   = 1'b1;
      end
      2'b11: begin
        if (i_prio == 1'b1) begin
          o_grant = 2'b10;
          o_gid   = 1'b1;
        end else begin
          o_grant = 2'b01;
          o_gid   = 1'b0;
        end
      end
      default: begin
        o_grant = 2'b00;
        o_gid   = 1'b0;
      end
    endcase
  end

endmodule : rr_arb2

// File: rtl/sram_arbiter.sv
// Shares one single-port sram between two requesters. The granted request
// drives the sram port in the same cycle; read data comes straight from the
// sram output register and is qualified by a one-cycle rsp_valid pulse.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   sram_we,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic [DATA_W-1:0]      sram_wdata,
  input  logic [DATA_W-1:0]      sram_rdata
);

  logic [NREQ-1:0] w_grant;
  req_id_t         w_gid;
  logic            w_xfer;
  req_id_t         r_prio;
  logic [NREQ-1:0] r_rd_q;

  rr_arb2 u_rr_arb2 (
    .i_valid (req_valid),
    .i_prio  (r_prio),
    .o_grant (w_grant),
    .o_gid   (w_gid)
  );

  // Nothing is accepted while reset is asserted.
  assign req_ready = w_grant & {NREQ{rst_n}};
  assign w_xfer    = |req_ready;

  // Route the granted requester onto the sram port; idle port drives zero.
  always_comb begin
    sram_we    = 1'b0;
    sram_addr  = {ADDR_W{1'b0}};
    sram_wdata = {DATA_W{1'b0}};
    if (w_xfer) begin
      case (w_gid)
        1'b0: begin
          sram_we    = req_we[0];
          sram_addr  = req_addr[0 +: ADDR_W];
          sram_wdata = req_wdata[0 +: DATA_W];
        end
        1'b1: begin
          sram_we    = req_we[1];
          sram_addr  = req_addr[ADDR_W +: ADDR_W];
          sram_wdata = req_wdata[DATA_W +: DATA_W];
        end
        default: begin
          sram_we    = 1'b0;
          sram_addr  = {ADDR_W{1'b0}};
          sram_wdata = {DATA_W{1'b0}};
        end
      endcase
    end else begin
      sram_we    = 1'b0;
      sram_addr  = {ADDR_W{1'b0}};
      sram_wdata = {DATA_W{1'b0}};
    end
  end

  // After a transfer, priority passes to the requester that did not win.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (w_xfer) begin
      r_prio <= ~w_gid;
    end else begin
      r_prio <= r_prio;
    end
  end

  // Remember which requester had a read accepted; sram data lands next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_q <= 2'b00;
    end else begin
      r_rd_q <= req_ready & ~req_we;
    end
  end

  assign rsp_valid = r_rd_q;
  assign rsp_rdata = sram_rdata;

endmodule : sram_arbiter

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural 16x8 sram attached.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        sram_we;
  logic [3:0]  sram_addr;
  logic [7:0]  sram_wdata;
  logic [7:0]  sram_rdata;
  logic [7:0]  mem [16];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Single-port sram with registered read data.
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    sram_rdata <= mem[sram_addr];
  end

  task automatic drive(input logic [1:0] v, input logic [1:0] we,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(2'b11, 2'b11, 4'd0, 4'd1, 8'h00, 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", req_ready); end
      n_cmp++; if (sram_we !== 1'b0) begin n_err++; $display("FAIL reset_sram_we: got %b want 0", sram_we); end
      n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
  endtask

  task automatic test_write_read;
    @(negedge clk);
    drive(2'b01, 2'b01, 4'd3, 4'd0, 8'hA5, 8'h00); #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL wr_ready: got %b want 01", req_ready); end
    n_cmp++; if (sram_we !== 1'b1) begin n_err++; $display("FAIL wr_sram_we: got %b want 1", sram_we); end
    n_cmp++; if (sram_addr !== 4'd3 || sram_wdata !== 8'hA5) begin n_err++; $display("FAIL wr_port: got %h/%h want 3/a5", sram_addr, sram_wdata); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL wr_no_rsp: got %b want 00", rsp_valid); end
    drive(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00); #1;
    n_cmp++; if (sram_we !== 1'b0) begin n_err++; $display("FAIL rd_sram_we: got %b want 0", sram_we); end
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rd_ready: got %b want 01", req_ready); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL rd_rsp_valid: got %b want 01", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 8'hA5) begin n_err++; $display("FAIL rd_rsp_rdata: got %h want a5", rsp_rdata); end
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
  endtask

  task automatic test_round_robin;
    // Preload: req0 writes addr 1, req1 writes addr 2 (leaves priority at 0).
    @(negedge clk);
    drive(2'b01, 2'b01, 4'd1, 4'd0, 8'h11, 8'h00);
    @(negedge clk);
    drive(2'b10, 2'b10, 4'd0, 4'd2, 8'h00, 8'h22);
    @(negedge clk);
    drive(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00); #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rr_grant0: got %b want 01", req_ready); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i % 2 == 1) begin
        n_cmp++; if (rsp_valid !== 2'b01 || rsp_rdata !== 8'h11) begin n_err++; $display("FAIL rr_rsp%0d: got %b/%h want 01/11", i, rsp_valid, rsp_rdata); end
      end else begin
        n_cmp++; if (rsp_valid !== 2'b10 || rsp_rdata !== 8'h22) begin n_err++; $display("FAIL rr_rsp%0d: got %b/%h want 10/22", i, rsp_valid, rsp_rdata); end
      end
      if (i < 4) begin
        #1;
        if (i % 2 == 1) begin
          n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL rr_grant%0d: got %b want 10", i, req_ready); end
        end else begin
          n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rr_grant%0d: got %b want 01", i, req_ready); end
        end
      end else begin
        drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
      end
    end
  endtask

  task automatic test_stream;
    logic [7:0] exp;
    // Fill all 16 words through req0; each write must assert sram_we.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      drive(2'b01, 2'b01, 4'(k), 4'd0, {4'h5, 4'(k)}, 8'h00); #1;
      n_cmp++; if (sram_we !== 1'b1) begin n_err++; $display("FAIL fill_we%0d: got %b want 1", k, sram_we); end
    end
    @(negedge clk);
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00); #1;
    n_cmp++; if (sram_we !== 1'b0 || rsp_valid !== 2'b00) begin n_err++; $display("FAIL fill_idle: got we=%b rsp=%b want 0/00", sram_we, rsp_valid); end
    for (int j = 0; j <= 16; j++) begin
      @(negedge clk);
      if (j > 0) begin
        exp = {4'h5, 4'(j - 1)};
        n_cmp++; if (rsp_valid !== 2'b10 || rsp_rdata !== exp) begin n_err++; $display("FAIL stream_rsp%0d: got %b/%h want 10/%h", j - 1, rsp_valid, rsp_rdata, exp); end
      end
      if (j < 16) begin
        drive(2'b10, 2'b00, 4'd0, 4'(j), 8'h00, 8'h00); #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL stream_ready%0d: got %b want 10", j, req_ready); end
      end else begin
        drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
      end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    drive(2'b01, 2'b01, 4'd7, 4'd0, 8'h3C, 8'h00); #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL b2b_wr_ready: got %b want 01", req_ready); end
    @(negedge clk);
    drive(2'b10, 2'b00, 4'd0, 4'd7, 8'h00, 8'h00); #1;
    n_cmp++; if (req_ready !== 2'b10 || sram_we !== 1'b0) begin n_err++; $display("FAIL b2b_rd_port: got %b/%b want 10/0", req_ready, sram_we); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL b2b_wr_no_rsp: got %b want 00", rsp_valid); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b10 || rsp_rdata !== 8'h3C) begin n_err++; $display("FAIL b2b_rsp: got %b/%h want 10/3c", rsp_valid, rsp_rdata); end
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
  endtask

  task automatic test_reset_mid_read;
    // req0 read moves priority to 1 before reset.
    @(negedge clk);
    drive(2'b01, 2'b00, 4'd7, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b01 || rsp_rdata !== 8'h3C) begin n_err++; $display("FAIL mr_rsp: got %b/%h want 01/3c", rsp_valid, rsp_rdata); end
    rst_n = 1'b0;
    drive(2'b11, 2'b00, 4'd7, 4'd3, 8'h00, 8'h00); #1;
    n_cmp++; if (req_ready !== 2'b00 || sram_we !== 1'b0) begin n_err++; $display("FAIL mr_rst_port: got %b/%b want 00/0", req_ready, sram_we); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL mr_squash: got %b want 00", rsp_valid); end
    rst_n = 1'b1; #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL mr_prio_reset: got %b want 01", req_ready); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b01 || rsp_rdata !== 8'h3C) begin n_err++; $display("FAIL mr_keep7: got %b/%h want 01/3c", rsp_valid, rsp_rdata); end
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL mr_grant1: got %b want 10", req_ready); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b10 || rsp_rdata !== 8'h53) begin n_err++; $display("FAIL mr_keep3: got %b/%h want 10/53", rsp_valid, rsp_rdata); end
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00); #1;
    n_cmp++; if (sram_we !== 1'b0) begin n_err++; $display("FAIL mr_idle_we: got %b want 0", sram_we); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL mr_idle_rsp: got %b want 00", rsp_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_stream();
    test_back_to_back();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sram_arbiter
